regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 19 +
 rtl/regfile_arbiter_rr_pick.sv | 29 ++
 rtl/regfile_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and default parameters for the round-robin arbitrated register file.
package regfile_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned NREQ_DEF     = 3;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned WIDTH_DEF    = 8;
    localparam int unsigned MAX_HOLD_DEF = 4;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot result.
module rr_pick
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick_c
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        pick_c = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                pick_c[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Register file shared by NREQ requesters; one owner at a time, round-robin,
// at most MAX_HOLD accesses per grant and one idle cycle between grants.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned AW       = idx_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ-1:0][AW-1:0]    addr,
    input  logic [NREQ-1:0][WIDTH-1:0] wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid
);

    localparam int unsigned PW = idx_w(NREQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    logic [NREQ-1:0]  pick_c;
    logic [PW-1:0]    pick_idx_c;
    logic [PW-1:0]    gidx_c;
    logic             req_sel_c;
    logic             we_sel_c;
    logic [AW-1:0]    addr_sel_c;
    logic [WIDTH-1:0] wdata_sel_c;
    logic             addr_ok_c;
    logic [WIDTH-1:0] rd_val_c;
    logic             hold_rel_c;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .pick_c (pick_c)
    );

    // Decode the current owner and the newly picked index from their one-hot forms.
    always_comb begin
        gidx_c     = '0;
        pick_idx_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_q[k])  gidx_c     = PW'(k);
            if (pick_c[k]) pick_idx_c = PW'(k);
        end
        req_sel_c   = req[gidx_c];
        we_sel_c    = we[gidx_c];
        addr_sel_c  = addr[gidx_c];
        wdata_sel_c = wdata[gidx_c];
        addr_ok_c   = 32'(addr_sel_c) < DEPTH;
        rd_val_c    = addr_ok_c ? regs_q[addr_sel_c] : '0;
        hold_rel_c  = (state_q == BUSY) && req_sel_c && (hold_q == HW'(MAX_HOLD - 1));
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick_c;
                    ptr_d   = (32'(pick_idx_c) == NREQ - 1) ? '0 : pick_idx_c + PW'(1);
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (req_sel_c) begin
                    if (we_sel_c) begin
                        if (addr_ok_c) regs_d[addr_sel_c] = wdata_sel_c;
                    end else begin
                        rdata_d  = rd_val_c;
                        rvalid_d = 1'b1;
                    end
                    if (hold_rel_c) begin
                        gnt_d   = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    gnt_d   = '0;
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            regs_q   <= regs_d;
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

    // Protocol invariants, checked only once reset has been released for a full cycle.
    always @(posedge clk) begin
        if (rst_n && $past(rst_n)) begin
            assert ($onehot0(gnt_q));
            assert (32'(hold_q) <= MAX_HOLD);
            if (rvalid_q) begin
                assert ($past((state_q == BUSY) && (|(gnt_q & req & ~we))));
                assert (rdata_q == $past(rd_val_c));
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cov_gnt
        cover property (@(posedge clk) disable iff (!rst_n) gnt_q[i]);
    end
    cover property (@(posedge clk) disable iff (!rst_n) hold_rel_c);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed plus random checks of regfile_arbiter against a behavioural ownership model.
module tb_regfile_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 3;
    localparam int W     = 8;
    localparam int MAXH  = 4;
    localparam int DEPTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req, we;
    logic [NREQ-1:0][AW-1:0] addr;
    logic [NREQ-1:0][W-1:0]  wdata;
    logic [NREQ-1:0]       gnt;
    logic [W-1:0]          rdata;
    logic                  rvalid;

    // Second instance with nine registers so addr 9 is expressible and out of range.
    logic [NREQ-1:0]         o_req, o_we;
    logic [NREQ-1:0][3:0]    o_addr;
    logic [NREQ-1:0][W-1:0]  o_wdata;
    logic [NREQ-1:0]         o_gnt;
    logic [W-1:0]            o_rdata;
    logic                    o_rvalid;

    int total = 0;
    int bad   = 0;

    // Model: who owns the file (-1 none), next-priority index, accesses used, contents.
    int          m_owner;
    int          m_ptr;
    int          m_used;
    logic [W-1:0] m_regs [DEPTH];
    logic [W-1:0] m_rdata;
    logic        m_rvalid;

    regfile_arbiter u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    regfile_arbiter #(.DEPTH(9)) u_oor (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (o_req),
        .we     (o_we),
        .addr   (o_addr),
        .wdata  (o_wdata),
        .gnt    (o_gnt),
        .rdata  (o_rdata),
        .rvalid (o_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_used   = 0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int a;
        m_rvalid = 1'b0;
        if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (m_owner < 0 && req[c]) m_owner = c;
                end
                m_ptr  = (m_owner + 1) % NREQ;
                m_used = 0;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_used  = 0;
        end else begin
            a = int'(addr[m_owner]);
            if (we[m_owner]) begin
                if (a < DEPTH) m_regs[a] = wdata[m_owner];
            end else begin
                m_rdata  = (a < DEPTH) ? m_regs[a] : '0;
                m_rvalid = 1'b1;
            end
            m_used++;
            if (m_used == MAXH) begin
                m_owner = -1;
                m_used  = 0;
            end
        end
    endtask

    function automatic logic [NREQ-1:0] m_gnt();
        return (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    endfunction

    // One clock: step the model, then compare all outputs 1 time unit after the edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".gnt"},    32'(gnt),    32'(m_gnt()));
        check({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
        check({tag, ".rdata"},  32'(rdata),  32'(m_rdata));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.gnt",    32'(gnt),    32'(0));
        check("rst.rvalid", 32'(rvalid), 32'(0));
        check("rst.rdata",  32'(rdata),  32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [NREQ-1:0] exp_seq [21];

    initial begin
        rst_n   = 1'b1;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        o_req   = '0;
        o_we    = '0;
        o_addr  = '0;
        o_wdata = '0;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("por.gnt",    32'(gnt),    32'(0));
        check("por.rvalid", 32'(rvalid), 32'(0));
        check("por.rdata",  32'(rdata),  32'(0));
        check("por.o_gnt",  32'(o_gnt),  32'(0));
        @(posedge clk);
        #1;
        check("por_clk.gnt", 32'(gnt), 32'(0));
        rst_n = 1'b1;

        // All three requesting: 4 accesses per grant, one idle cycle between grants.
        for (int k = 0; k < 21; k++) exp_seq[k] = '0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) exp_seq[g * 5 + k] = NREQ'(1 << (g % NREQ));
        req = 3'b111;
        for (int k = 0; k < 16; k++) begin
            addr[0] = AW'(k); addr[1] = AW'(k + 1); addr[2] = AW'(k + 2);
            cyc("rr");
            check("rr.seq", 32'(gnt), 32'(exp_seq[k]));
        end

        // Requester 0 writes A5 to addr 3, then reads it back.
        do_reset();
        req = 3'b001; we = 3'b001; addr[0] = 3'd3; wdata[0] = 8'hA5;
        cyc("wr.grant");
        cyc("wr.write");
        we = 3'b000;
        cyc("wr.read");
        check("wr.rdata",  32'(rdata),  32'h0A5);
        check("wr.rvalid", 32'(rvalid), 32'(1));
        req = 3'b000;
        cyc("wr.drop");
        check("wr.rvalid_pulse", 32'(rvalid), 32'(0));

        // Requester 1 drops after two accesses; requester 2 gets the next grant.
        do_reset();
        req = 3'b010; we = 3'b000; addr[1] = 3'd3;
        cyc("drop.grant");
        check("drop.g1", 32'(gnt), 32'(3'b010));
        req = 3'b110;
        cyc("drop.acc1");
        cyc("drop.acc2");
        req = 3'b100;
        cyc("drop.release");
        check("drop.clear", 32'(gnt), 32'(0));
        cyc("drop.next");
        check("drop.g2", 32'(gnt), 32'(3'b100));
        // Full hold proves the count restarted from zero after the early release.
        for (int k = 0; k < 4; k++) cyc("drop.hold");
        check("drop.hold_end", 32'(gnt), 32'(0));
        req = 3'b000;
        cyc("drop.idle");

        // Reset asserted with a write to addr 5 pending.
        req = 3'b001; we = 3'b001; addr[0] = 3'd5; wdata[0] = 8'h3C;
        cyc("mid.grant");
        cyc("mid.write");
        wdata[0] = 8'hC3;
        cyc("mid.rd_pre");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid.gnt",    32'(gnt),    32'(0));
        check("mid.rvalid", 32'(rvalid), 32'(0));
        check("mid.rdata",  32'(rdata),  32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 3'b100; we = 3'b000; addr[2] = 3'd5;
        req = 3'b101;
        cyc("mid.regrant");
        check("mid.lowest", 32'(gnt), 32'(3'b001));
        we = 3'b000;
        cyc("mid.read5");
        check("mid.reg5",    32'(rdata),  32'(0));
        check("mid.rvalid5", 32'(rvalid), 32'(1));
        req = 3'b000;
        cyc("mid.idle");

        // Out-of-range address on the nine-register instance.
        do_reset();
        o_req = 3'b001; o_we = 3'b001; o_addr[0] = 4'd2; o_wdata[0] = 8'h5A;
        @(posedge clk); #1;
        check("oor.grant", 32'(o_gnt), 32'(3'b001));
        @(posedge clk); #1;
        o_we = 3'b000;
        @(posedge clk); #1;
        check("oor.rd2", 32'(o_rdata), 32'h5A);
        o_we = 3'b001; o_addr[0] = 4'd9; o_wdata[0] = 8'hFF;
        @(posedge clk); #1;
        check("oor.wr9_rvalid", 32'(o_rvalid), 32'(0));
        o_we = 3'b000;
        @(posedge clk); #1;
        check("oor.rd9",        32'(o_rdata),  32'(0));
        check("oor.rd9_rvalid", 32'(o_rvalid), 32'(1));
        check("oor.hold_rel",   32'(o_gnt),    32'(0));
        o_addr[0] = 4'd2;
        @(posedge clk); #1;
        check("oor.regrant", 32'(o_gnt), 32'(3'b001));
        @(posedge clk); #1;
        check("oor.rd2b", 32'(o_rdata), 32'h5A);
        o_addr[0] = 4'd1;
        @(posedge clk); #1;
        check("oor.rd1", 32'(o_rdata), 32'(0));
        o_addr[0] = 4'd8;
        @(posedge clk); #1;
        check("oor.rd8", 32'(o_rdata), 32'(0));
        o_req = 3'b000;
        @(posedge clk); #1;
        // Main instance was idle throughout; resynchronise its model.
        do_reset();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req[i]   = ($urandom_range(0, 4) != 0);
                we[i]    = $urandom_range(0, 1) == 1;
                addr[i]  = AW'($urandom_range(0, DEPTH - 1));
                wdata[i] = W'($urandom);
            end
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
